// File: rtl/vga_timing_gen.sv
// VGA timing generator: programmable porches/sync/polarity, pixel-enable
// qualified counters, registered aligned outputs and a built-in test pattern.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter bit H_POL      = 1'b1,
    parameter bit V_POL      = 1'b1,
    parameter int CBITS      = 1,
    parameter int CHECK_LOG2 = 5,
    localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_en,
    input  logic [1:0]           pattern_sel,
    input  logic [3*CBITS-1:0]   solid_color,
    output logic                 h_sync_out,
    output logic                 v_sync_out,
    output logic                 de,
    output logic [HW-1:0]        pixel_x,
    output logic [VW-1:0]        pixel_y,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [3*CBITS-1:0]   rgb
);

    localparam int BAR_W = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] BAR_LOAD   = HW'(BAR_W - 1);

    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    logic [HW-1:0]      hc;
    logic [VW-1:0]      vc;
    logic [1:0]         pat_q;
    logic [HW-1:0]      bar_left;
    logic [2:0]         bar_idx;

    logic               h_act, v_act, h_syn, v_syn, origin, chk_bit, border;
    logic [1:0]         pat_now;
    logic [3*CBITS-1:0] rgb_next;

    // Region decode and pattern colour for the pixel at (hc, vc).
    always_comb begin
        h_act   = hc < H_ACT_END;
        v_act   = vc < V_ACT_END;
        h_syn   = (hc >= H_SYNC_BEG) && (hc < H_SYNC_END);
        v_syn   = (vc >= V_SYNC_BEG) && (vc < V_SYNC_END);
        origin  = (hc == '0) && (vc == '0);
        // the first pixel of a frame already uses the newly latched pattern
        pat_now = origin ? pattern_sel : pat_q;
        chk_bit = (((hc >> CHECK_LOG2) ^ HW'(vc >> CHECK_LOG2)) & HW'(1)) != '0;
        border  = (hc == '0) || (hc == H_ACT_LAST) || (vc == '0) || (vc == V_ACT_LAST);
        rgb_next = '0;
        if (h_act && v_act) begin
            case (pat_now)
                2'd0:    rgb_next = {{CBITS{bar_idx[2]}}, {CBITS{bar_idx[1]}}, {CBITS{bar_idx[0]}}};
                2'd1:    rgb_next = chk_bit ? '1 : '0;
                2'd2:    rgb_next = solid_color;
                default: rgb_next = border ? '1 : '0;
            endcase
        end
    end

    // Counters, bar tracker, pattern latch and registered outputs, all pix_en qualified.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            pat_q       <= '0;
            bar_left    <= BAR_LOAD;
            bar_idx     <= '0;
            h_sync_out  <= ~H_POL;
            v_sync_out  <= ~V_POL;
            de          <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            rgb         <= '0;
        end else if (pix_en) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end

            // bar index follows hc without a divider; saturates at the last bar
            if (hc == H_LAST) begin
                bar_left <= BAR_LOAD;
                bar_idx  <= '0;
            end else if (bar_left == '0) begin
                bar_left <= BAR_LOAD;
                if (bar_idx != 3'd7)
                    bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_left <= bar_left - 1'b1;
            end

            if (origin)
                pat_q <= pattern_sel;

            h_sync_out  <= h_syn ? H_POL : ~H_POL;
            v_sync_out  <= v_syn ? V_POL : ~V_POL;
            de          <= h_act && v_act;
            pixel_x     <= hc;
            pixel_y     <= vc;
            line_start  <= (hc == '0);
            frame_start <= origin;
            rgb         <= rgb_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small 16x8 configuration, two polarities,
// directed scenarios plus randomized pix_en/pattern/reset traffic.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 16
    localparam int VT = VA + VF + VS + VB;   // 8
    localparam int FRAME = HT * VT;          // 128

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic [2:0] solid_color = 3'd0;

    logic       hs, vs, de, ls, fs;
    logic [3:0] px;
    logic [2:0] py;
    logic [2:0] rgb;

    logic       hs_n, vs_n, de_n, ls_n, fs_n;
    logic [3:0] px_n;
    logic [2:0] py_n;
    logic [2:0] rgb_n;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: position of the next pixel to be emitted and the frame pattern
    int mx, my, mpat;
    int e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs, e_rgb;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1'b1), .V_POL(1'b1), .CBITS(1), .CHECK_LOG2(1)
    ) u_dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .pattern_sel(pattern_sel), .solid_color(solid_color),
        .h_sync_out(hs), .v_sync_out(vs), .de(de),
        .pixel_x(px), .pixel_y(py), .line_start(ls), .frame_start(fs), .rgb(rgb)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1'b0), .V_POL(1'b0), .CBITS(1), .CHECK_LOG2(1)
    ) u_neg (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .pattern_sel(pattern_sel), .solid_color(solid_color),
        .h_sync_out(hs_n), .v_sync_out(vs_n), .de(de_n),
        .pixel_x(px_n), .pixel_y(py_n), .line_start(ls_n), .frame_start(fs_n), .rgb(rgb_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pattern_color(input int x, input int y, input int pat, input int solid);
        int b;
        if (!(x < HA && y < VA)) return 0;
        case (pat)
            0: begin
                b = x / (HA / 8);
                if (b > 7) b = 7;
                return b;
            end
            1: return ((((x / 2) % 2) ^ ((y / 2) % 2)) != 0) ? 7 : 0;
            2: return solid;
            default: return (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? 7 : 0;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit en);
        if (r) begin
            mx = 0; my = 0; mpat = 0;
            e_hs = 0; e_vs = 0; e_de = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0; e_rgb = 0;
        end else if (en) begin
            if (mx == 0 && my == 0) mpat = int'(pattern_sel);
            e_x   = mx;
            e_y   = my;
            e_de  = (mx < HA && my < VA) ? 1 : 0;
            e_hs  = (mx >= HA + HF && mx < HA + HF + HS) ? 1 : 0;
            e_vs  = (my >= VA + VF && my < VA + VF + VS) ? 1 : 0;
            e_ls  = (mx == 0) ? 1 : 0;
            e_fs  = (mx == 0 && my == 0) ? 1 : 0;
            e_rgb = pattern_color(mx, my, mpat, int'(solid_color));
            mx = mx + 1;
            if (mx == HT) begin
                mx = 0;
                my = (my + 1) % VT;
            end
        end
    endtask

    task automatic cmp_all();
        check("hsync", hs, e_hs);
        check("vsync", vs, e_vs);
        check("de", de, e_de);
        check("pixel_x", px, e_x);
        check("pixel_y", py, e_y);
        check("line_start", ls, e_ls);
        check("frame_start", fs, e_fs);
        check("rgb", rgb, e_rgb);
        check("hsync_lowpol", hs_n, 1 - e_hs);
        check("vsync_lowpol", vs_n, 1 - e_vs);
    endtask

    task automatic tick(input bit r, input bit en);
        reset  = r;
        pix_en = en;
        @(posedge clk);
        model_step(r, en);
        #1;
        cmp_all();
    endtask

    initial begin
        int fs_cnt, vs_cnt, ls_cnt, first_fs, second_fs;
        bit found;

        // reset state
        tick(1, 1);
        tick(1, 0);
        check("rst_hs", hs, 0);
        check("rst_hs_lowpol", hs_n, 1);
        check("rst_rgb", rgb, 0);

        // continuous pix_en: two frames
        fs_cnt = 0; vs_cnt = 0; ls_cnt = 0; first_fs = -1; second_fs = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(0, 1);
            if (fs) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = i; else if (second_fs < 0) second_fs = i;
            end
            if (vs) vs_cnt++;
            if (ls) ls_cnt++;
        end
        check("fs_count", fs_cnt, 2);
        check("fs_first", first_fs, 0);
        check("fs_period", second_fs - first_fs, FRAME);
        check("vs_cycles", vs_cnt, 2 * VS * HT);
        check("ls_count", ls_cnt, 2 * VT);

        // reset at pixel (5,2), held 3 cycles
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick(0, 1);
            if (e_x == 5 && e_y == 2) found = 1;
        end
        check("wait_5_2", found, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1, 1);
            check("midrst_x", px, 0);
            check("midrst_fs", fs, 0);
        end
        tick(0, 1);
        check("post_rst_fs", fs, 1);
        check("post_rst_de", de, 1);
        check("post_rst_xy", {px, py}, 0);

        // pix_en duty 1 of 3: frame takes 3x the cycles, pulses held not re-fired
        tick(1, 1);
        first_fs = -1; second_fs = -1; ls_cnt = 0;
        for (int i = 0; i < 3 * FRAME + 6; i++) begin
            tick(0, (i % 3) == 0);
            if (pix_en && fs) begin
                if (first_fs < 0) first_fs = i; else if (second_fs < 0) second_fs = i;
            end
            if (pix_en && ls && i < 3 * FRAME) ls_cnt++;
        end
        check("slow_fs_period", second_fs - first_fs, 3 * FRAME);
        check("slow_ls_count", ls_cnt, VT);

        // pattern 0 -> 2 mid-frame, then the border pattern
        pattern_sel = 2'd0;
        tick(1, 1);
        for (int i = 0; i < FRAME + 40; i++) tick(0, 1);
        pattern_sel = 2'd2;
        solid_color = 3'b101;
        for (int i = 0; i < 2 * FRAME; i++) tick(0, 1);
        pattern_sel = 2'd3;
        for (int i = 0; i < 2 * FRAME; i++) tick(0, 1);
        pattern_sel = 2'd1;
        for (int i = 0; i < 2 * FRAME; i++) tick(0, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) pattern_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)  solid_color = 3'($urandom_range(0, 7));
            tick($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 800x600 sync counter.
- Generates complete VGA horizontal/vertical timing (active, front porch, sync, back porch), with programmable sync polarity and a pixel-clock enable.
- Provides registered pixel coordinates, display-enable and frame/line pulses.
- Drives a built-in test-pattern generator, so the board output can be brought up without a frame buffer.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BACK, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BACK, 23, vertical back porch (lines)
- H_POL, 1, hsync active level (1 = active-high)
- V_POL, 1, vsync active level
- CBITS, 1, bits per colour channel
- CHECK_LOG2, 5, checker square size = 2**CHECK_LOG2 pixels
- Derived, not overridable: H_TOTAL = sum of H_* (1056); V_TOTAL = sum of V_* (628); HW = clog2(H_TOTAL); VW = clog2(V_TOTAL).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel tick; timing advances only on cycles with pix_en=1
- pattern_sel  in  2  0 colour bars, 1 checker, 2 solid, 3 border
- solid_color  in  3*CBITS  colour for pattern 2, {R,G,B}
- h_sync_out  out  1  horizontal sync, polarity H_POL
- v_sync_out  out  1  vertical sync, polarity V_POL
- de  out  1  display enable (pixel in active area)
- pixel_x  out  HW  horizontal counter value of the current output pixel
- pixel_y  out  VW  vertical counter value of the current output pixel
- line_start  out  1  one pix_en-qualified pulse at pixel_x=0
- frame_start  out  1  one pix_en-qualified pulse at pixel_x=0, pixel_y=0
- rgb  out  3*CBITS  pixel colour {R,G,B}; 0 when de=0

Behaviour:
- Reset (synchronous, dominates pix_en):
  - Internal counters hc=vc=0.
  - Outputs: h_sync_out=~H_POL, v_sync_out=~V_POL, de=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0, rgb=0.
  - Latched pattern = 0.
- Counters, on a clk edge with pix_en=1:
  - hc increments; at H_TOTAL-1 it wraps to 0.
  - vc increments only when hc wraps; vc wraps to 0 at V_TOTAL-1 when hc also wraps.
- Output stage: all outputs are registered from the current hc/vc on the same pix_en edge that advances the counters. Latency counter->outputs is 1 pix_en tick; all outputs stay mutually aligned.
- With pix_en=0: counters and every output hold their value (no pulse re-fires, no decay).
- Regions, horizontal (vertical is identical using vc and the V_* parameters):
  - active: hc < H_ACTIVE
  - front porch: H_ACTIVE <= hc < H_ACTIVE+H_FRONT
  - sync: H_ACTIVE+H_FRONT <= hc < H_ACTIVE+H_FRONT+H_SYNC
  - back porch: the remainder
- h_sync_out = H_POL in the h-sync region, else ~H_POL. v_sync_out = V_POL in the v-sync region, else ~V_POL. v_sync changes only at hc=0 boundaries.
- de = 1 iff in both h-active and v-active regions.
- line_start = (hc==0); frame_start = (hc==0 && vc==0). Each is 1 for exactly one pix_en tick, then 0 on the next pix_en tick.
- Pattern latching: pattern_sel is captured into the latched pattern only when hc==0 && vc==0 and pix_en=1. The change therefore appears from the first pixel of the new frame, with no mid-frame tearing. solid_color is used live.
- Patterns (evaluated only when de=1; otherwise rgb=0):
  - Pattern 0: 8 vertical bars of width BAR_W = H_ACTIVE/8 (integer floor). Bar index b = min(x/BAR_W, 7), implemented with a bar counter, not a divider. Each channel is all-ones when its bit is set: R=b[2], G=b[1], B=b[0].
  - Pattern 1: checker. White (all ones) when x[CHECK_LOG2] ^ y[CHECK_LOG2] = 1, else black.
  - Pattern 2: rgb = solid_color.
  - Pattern 3: white when x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1; else black.
- Reset mid-frame: next cycle shows the reset values. Timing restarts at (0,0), with frame_start on the first pix_en tick after reset deasserts.
- Widths: counters are sized HW/VW; there is no overflow beyond TOTAL-1.

Test Plan:
- Small config (H 8/2/3/3, V 4/1/2/1, pix_en=1) -> H_TOTAL=16, frame=128 cycles. frame_start pulses every 128 cycles. h_sync_out high exactly at pixel_x 10..12 and de high at 0..7. v_sync_out high for pixel_y 5..6 (32 cycles).
- Reset asserted at pixel (5,2), held 3 cycles -> outputs read reset values during reset. The first pix_en tick after release gives pixel_x=0, pixel_y=0, frame_start=1, de=1.
- pix_en toggling 1,0,0,1 -> counters and all outputs hold across the two idle cycles. Total cycles per frame = 128 ticks × (cycles per tick). line_start is never double-pulsed.
- H_POL=0, V_POL=0 -> idle syncs read 1 and go to 0 in the same windows as the first test.
- pattern_sel changed 0->2 mid-frame with solid_color=3'b101 -> colour bars continue (x=0..7 give b=0..7) until the next frame_start. From then on, rgb=3'b101 whenever de=1 and rgb=0 in blanking.
- Pattern 3 on the small config -> rgb=3'b111 only at x in {0,7} or y in {0,3} within the active area; elsewhere 0.
